// File: rtl/fft_iter_core.sv
// ----------------------------------------------------------------------------
// fft_iter_core
//
// In-place radix-2 decimation-in-time FFT/IFFT of N = 2^LOG2N complex points.
// One butterfly is evaluated per clock over a register-file working memory.
// Samples are stored bit-reversed on load, processed stage by stage, and
// unloaded in natural bin order.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   sample stream in (handshake below)
//   in_real/in_imag     signed Q1.(DATA_WIDTH-1) sample
//   inverse, scale_en   frame mode, captured together with sample 0
//   out_valid/out_ready bin stream out (handshake below)
//   out_real/out_imag   signed bin value
//   out_index, out_last bin number (natural order), high on bin N-1
//   busy                high while computing or unloading
//   ovf                 sticky saturation flag for the current frame
//
// Handshake: a word moves on a rising edge where valid && ready are both high.
// A source holds its data stable until it moves; ready never depends on valid.
// ----------------------------------------------------------------------------
module fft_iter_core #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int LOG2N      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_real,
    input  logic [DATA_WIDTH-1:0] in_imag,
    input  logic                  inverse,
    input  logic                  scale_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic [LOG2N-1:0]      out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  ovf
);
    localparam int  N     = 1 << LOG2N;
    localparam int  HALF  = N / 2;
    localparam int  BW    = LOG2N - 1;
    localparam int  SW    = $clog2(LOG2N);
    localparam int  PW    = DATA_WIDTH + TW_WIDTH;
    localparam int  EW    = DATA_WIDTH + 2;
    localparam int  TWMAX = (1 << (TW_WIDTH - 1)) - 1;
    localparam real PI    = 3.14159265358979323846;

    localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);
    localparam logic [LOG2N-1:0] CNT_MAX    = {LOG2N{1'b1}};
    localparam logic [BW-1:0]    BFLY_MAX   = {BW{1'b1}};
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic signed [EW-1:0] SAT_HI = EW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_LO = EW'(-(1 << (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t           state, state_nx;
    logic [LOG2N-1:0] cnt;      // sample counter in LOAD, bin counter in UNLOAD
    logic [SW-1:0]    stage;    // 0-based stage, span h = 2^stage
    logic [BW-1:0]    bfly;     // butterfly within the stage
    logic             run;      // low on the first COMPUTE cycle
    logic             inv_q, scl_q, ovf_q;
    logic             in_xfer, out_xfer, last_bfly, bf_ovf;

    logic signed [DATA_WIDTH-1:0] mem_re [N];
    logic signed [DATA_WIDTH-1:0] mem_im [N];

    // ---------------- twiddle ROM, round half away from zero ----------------
    function automatic logic signed [TW_WIDTH-1:0] tw_round(input real v);
        real r;
        r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
        return TW_WIDTH'($rtoi(r));
    endfunction

    logic signed [TW_WIDTH-1:0] tw_re [HALF];
    logic signed [TW_WIDTH-1:0] tw_im [HALF];

    for (genvar k = 0; k < HALF; k++) begin : g_tw
        assign tw_re[k] =  tw_round($cos(2.0 * PI * real'(k) / real'(N)) * real'(TWMAX));
        assign tw_im[k] = -tw_round($sin(2.0 * PI * real'(k) / real'(N)) * real'(TWMAX));
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int j = 0; j < LOG2N; j++) r[j] = v[LOG2N-1-j];
        return r;
    endfunction

    function automatic logic signed [EW-1:0] scale_fn(input logic signed [EW-1:0] v,
                                                      input logic en);
        return en ? (v >>> 1) : v;
    endfunction

    function automatic logic over_fn(input logic signed [EW-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [EW-1:0] v);
        if (v > SAT_HI) return DATA_WIDTH'(SAT_HI);
        if (v < SAT_LO) return DATA_WIDTH'(SAT_LO);
        return DATA_WIDTH'(v);
    endfunction

    // ---------------- butterfly address generation ----------------
    logic [LOG2N-1:0] h, b_ext, i_idx, addr_a, addr_b;
    logic [BW-1:0]    tw_k;

    always_comb begin
        h      = ONE << stage;
        b_ext  = {1'b0, bfly};
        i_idx  = b_ext & (h - ONE);
        // clearing the low 'stage' bits gives g*h; one more shift gives g*2h
        addr_a = (((b_ext >> stage) << stage) << 1) | i_idx;
        addr_b = addr_a | h;
        tw_k   = BW'(i_idx << (LAST_STAGE - stage));
    end

    // ---------------- butterfly datapath ----------------
    logic signed [DATA_WIDTH-1:0] ar, ai, br, bi;
    logic signed [TW_WIDTH-1:0]   wr, wi;
    logic signed [PW-1:0]         m_rr, m_ii, m_ri, m_ir;
    logic signed [PW:0]           pr, pi;
    logic signed [DATA_WIDTH:0]   tr, ti;
    logic signed [EW-1:0]         s_re, s_im, d_re, d_im;

    always_comb begin
        ar   = mem_re[addr_a];
        ai   = mem_im[addr_a];
        br   = mem_re[addr_b];
        bi   = mem_im[addr_b];
        wr   = tw_re[tw_k];
        wi   = inv_q ? -tw_im[tw_k] : tw_im[tw_k];
        m_rr = PW'(br) * PW'(wr);
        m_ii = PW'(bi) * PW'(wi);
        m_ri = PW'(br) * PW'(wi);
        m_ir = PW'(bi) * PW'(wr);
        pr   = (PW+1)'(m_rr) - (PW+1)'(m_ii);
        pi   = (PW+1)'(m_ri) + (PW+1)'(m_ir);
        tr   = (DATA_WIDTH+1)'(pr >>> (TW_WIDTH - 1));
        ti   = (DATA_WIDTH+1)'(pi >>> (TW_WIDTH - 1));
        s_re = scale_fn(EW'(ar) + EW'(tr), scl_q);
        s_im = scale_fn(EW'(ai) + EW'(ti), scl_q);
        d_re = scale_fn(EW'(ar) - EW'(tr), scl_q);
        d_im = scale_fn(EW'(ai) - EW'(ti), scl_q);
        bf_ovf = over_fn(s_re) | over_fn(s_im) | over_fn(d_re) | over_fn(d_im);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && cnt == CNT_MAX) state_nx = COMPUTE;
            end
            COMPUTE: if (last_bfly) state_nx = UNLOAD;
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready && cnt == CNT_MAX) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_bfly = run && (stage == LAST_STAGE) && (bfly == BFLY_MAX);
    assign out_index = out_valid ? cnt : '0;
    assign out_last  = out_valid && (cnt == CNT_MAX);
    assign out_real  = mem_re[cnt];
    assign out_imag  = mem_im[cnt];
    assign ovf       = ovf_q;

    // ---------------- counters and frame mode ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            stage <= '0;
            bfly  <= '0;
            run   <= 1'b0;
            inv_q <= 1'b0;
            scl_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_xfer) begin
                    cnt <= cnt + ONE;   // wraps to 0 after sample N-1
                    if (cnt == '0) begin
                        inv_q <= inverse;
                        scl_q <= scale_en;
                        ovf_q <= 1'b0;
                    end
                end
                COMPUTE: begin
                    // The first COMPUTE cycle only arms the sequencer; the
                    // butterflies run on the following LOG2N*N/2 cycles.
                    if (!run) begin
                        run <= 1'b1;
                    end else begin
                        if (bf_ovf) ovf_q <= 1'b1;
                        bfly <= bfly + BW'(1);
                        if (bfly == BFLY_MAX)
                            stage <= (stage == LAST_STAGE) ? '0 : stage + SW'(1);
                        if (last_bfly) run <= 1'b0;
                    end
                end
                UNLOAD: if (out_xfer) cnt <= cnt + ONE;
                default: ;
            endcase
        end
    end

    // ---------------- working memory (not reset) ----------------
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem_re[bitrev(cnt)] <= in_real;
            mem_im[bitrev(cnt)] <= in_imag;
        end else if (state == COMPUTE && run) begin
            mem_re[addr_a] <= sat_fn(s_re);
            mem_im[addr_a] <= sat_fn(s_im);
            mem_re[addr_b] <= sat_fn(d_re);
            mem_im[addr_b] <= sat_fn(d_im);
        end
    end

endmodule

// File: tb/tb_fft_iter_core.sv
// ----------------------------------------------------------------------------
// tb_fft_iter_core
//
// Self-checking bench for fft_iter_core (LOG2N = 6). A stage-by-stage integer
// FFT model fills an expected queue for each frame; bins coming out of the
// core are compared against it every cycle out_valid is high. Hand-derived
// literal bins pin the model for impulse, DC, single-tone and overflow frames.
// ----------------------------------------------------------------------------
module tb_fft_iter_core;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int LOG2N = 6;
  localparam int N     = 1 << LOG2N;
  localparam int LAT   = LOG2N * N / 2 + 1;
  localparam real PI   = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DW-1:0]        in_real = '0;
  logic [DW-1:0]        in_imag = '0;
  logic                 inverse = 1'b0;
  logic                 scale_en = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic [LOG2N-1:0]     out_index;
  logic                 out_last;
  logic                 busy;
  logic                 ovf;

  fft_iter_core #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .inverse(inverse), .scale_en(scale_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last),
    .busy(busy), .ovf(ovf)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  int x_re[N];
  int x_im[N];
  int got_re[N];
  int got_im[N];
  logic [2*DW-1:0] exp_q[$];
  bit exp_ovf = 1'b0;
  bit prev_ovf = 1'b0;
  bit got_ovf = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rev(input int v);
    int r = 0;
    for (int j = 0; j < LOG2N; j++) if (v[j]) r |= 1 << (LOG2N - 1 - j);
    return r;
  endfunction

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($floor(r + 0.5));
    return -longint'($floor(-r + 0.5));
  endfunction

  function automatic longint wrapw(input longint v, input int w);
    longint m = longint'(1) << w;
    v = v & (m - 1);
    if (v >= (m >> 1)) v -= m;
    return v;
  endfunction

  function automatic longint fit(input longint v, input bit scl, output bit o);
    longint lim = longint'(1) << (DW - 1);
    if (scl) v = v >>> 1;
    o = 1'b0;
    if (v > lim - 1) begin v = lim - 1; o = 1'b1; end
    else if (v < -lim) begin v = -lim; o = 1'b1; end
    return v;
  endfunction

  task automatic run_model(input bit inv, input bit scl);
    longint re[N];
    longint im[N];
    longint wmax, wr, wi, tr, ti, ar, ai, br, bi;
    bit o;
    wmax = (longint'(1) << (TW - 1)) - 1;
    exp_ovf = 1'b0;
    for (int n = 0; n < N; n++) begin
      re[rev(n)] = x_re[n];
      im[rev(n)] = x_im[n];
    end
    for (int h = 1; h < N; h = h * 2)
      for (int base = 0; base < N; base += 2 * h)
        for (int i = 0; i < h; i++) begin
          int k, a, b;
          k = i * (N / (2 * h));
          a = base + i;
          b = a + h;
          wr = rnd(real'(wmax) * $cos(2.0 * PI * k / N));
          wi = -rnd(real'(wmax) * $sin(2.0 * PI * k / N));
          if (inv) wi = -wi;
          ar = re[a]; ai = im[a]; br = re[b]; bi = im[b];
          tr = wrapw((br * wr - bi * wi) >>> (TW - 1), DW + 1);
          ti = wrapw((br * wi + bi * wr) >>> (TW - 1), DW + 1);
          re[a] = fit(ar + tr, scl, o); exp_ovf |= o;
          im[a] = fit(ai + ti, scl, o); exp_ovf |= o;
          re[b] = fit(ar - tr, scl, o); exp_ovf |= o;
          im[b] = fit(ai - ti, scl, o); exp_ovf |= o;
        end
    exp_q.delete();
    for (int n = 0; n < N; n++) exp_q.push_back({DW'(re[n]), DW'(im[n])});
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at a negedge.
  task automatic load_frame(input bit inv, input bit scl, input bit gaps);
    int n = 0;
    int guard = 0;
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
    check("ovf_held_until_sample0", ovf, prev_ovf);
    while (n < N && guard < 2000) begin
      guard++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_real  = DW'(x_re[n]);
      in_imag  = DW'(x_im[n]);
      inverse  = (n == 0) ? inv : 1'($urandom);
      scale_en = (n == 0) ? scl : 1'($urandom);
      @(posedge clk);
      if (in_valid) n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("load_count", n, N);
  endtask

  task automatic wait_compute();
    int lat = 0;
    while (!out_valid && lat < 1000) begin
      check("compute_in_ready", in_ready, 0);
      check("compute_busy", busy, 1);
      // junk offered while the core is not ready must be ignored
      in_valid = 1'($urandom);
      in_real  = DW'($urandom);
      in_imag  = DW'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", lat, LAT);
  endtask

  task automatic unload_frame(input bit rnd_ready, input int stall_at);
    int idx = 0;
    int guard = 0;
    int held = 0;
    logic [2*DW-1:0] e;
    logic signed [DW-1:0] er, ei;
    while (idx < N && guard < 4000) begin
      guard++;
      check("out_valid", out_valid, 1);
      if (!out_valid) break;
      e  = exp_q[0];
      er = e[2*DW-1:DW];
      ei = e[DW-1:0];
      check("out_index", out_index, idx);
      check("out_last", out_last, idx == N - 1);
      check("out_real", out_real, er);
      check("out_imag", out_imag, ei);
      check("out_ovf", ovf, exp_ovf);
      check("unload_busy", busy, 1);
      check("unload_in_ready", in_ready, 0);
      got_re[idx] = int'(out_real);
      got_im[idx] = int'(out_imag);
      got_ovf     = ovf;
      if (idx == stall_at && held < 5) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(posedge clk);
      if (out_ready) begin
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("unload_count", idx, N);
    if (stall_at >= 0) check("stall_cycles", held, 5);
    check("done_out_valid", out_valid, 0);
    check("done_in_ready", in_ready, 1);
    check("done_busy", busy, 0);
  endtask

  task automatic run_frame(input bit inv, input bit scl, input bit gaps,
                           input bit rnd_ready, input int stall_at);
    run_model(inv, scl);
    load_frame(inv, scl, gaps);
    wait_compute();
    unload_frame(rnd_ready, stall_at);
    prev_ovf = exp_ovf;
  endtask

  task automatic fill(input int re_v, input int im_v);
    for (int n = 0; n < N; n++) begin
      x_re[n] = re_v;
      x_im[n] = im_v;
    end
  endtask

  task automatic check_impulse();
    for (int k = 0; k < N; k++) begin
      check("impulse_re", got_re[k], 256);
      check("impulse_im", got_im[k], 0);
    end
    check("impulse_ovf", got_ovf, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_index", out_index, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // impulse: 16384 halved over six stages -> 256 in every bin
    fill(0, 0);
    x_re[0] = 16384;
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_impulse();

    // DC: the unit twiddle is 32767/32768, so bin 0 loses one LSB per
    // stage (1024 -> 1018) and every other bin cancels to exactly 0
    fill(1024, 0);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, -1);
    check("dc_bin0_re", got_re[0], 1018);
    check("dc_bin0_im", got_im[0], 0);
    for (int k = 1; k < N; k++) begin
      check("dc_bin_re", got_re[k], 0);
      check("dc_bin_im", got_im[k], 0);
    end

    // single tone at x[1]: bin 16 is 256*W^16/2, floor gives -128 / +127
    fill(0, 0);
    x_re[1] = 8192;
    run_frame(1'b0, 1'b1, 1'b1, 1'b1, -1);
    check("fwd_bin16_re", got_re[16], 0);
    check("fwd_bin16_im", got_im[16], -128);
    run_frame(1'b1, 1'b1, 1'b1, 1'b1, -1);
    check("inv_bin16_re", got_re[16], 0);
    check("inv_bin16_im", got_im[16], 127);

    // overflow without scaling, then a clean frame clears the flag
    fill(32767, 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1);
    check("ovf_set", got_ovf, 1);
    check("ovf_bin0_re", got_re[0], 32767);
    fill(0, 0);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, -1);
    check("ovf_cleared", got_ovf, 0);

    // random data, random gaps and back-pressure, one 5-cycle stall at bin 10
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < N; n++) begin
        x_re[n] = int'($urandom_range(0, 65535)) - 32768;
        x_im[n] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_frame(1'($urandom), 1'($urandom), 1'b1, 1'b1, (f == 0) ? 10 : -1);
    end

    // reset in the middle of COMPUTE of a saturating frame
    fill(32767, 0);
    load_frame(1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);
    rst_n = 1'b1;
    prev_ovf = 1'b0;
    @(negedge clk);
    fill(0, 0);
    x_re[0] = 16384;
    run_frame(1'b0, 1'b1, 1'b1, 1'b1, -1);
    check_impulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
